// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 control unit: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with memory handshakes.
// Optional: define CTRL_ILLEGAL_TRAP_EN to park illegal opcodes in TRAP; otherwise they retire as NOPs.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             nReset,
  input  logic [10:0]      OPCode,
  input  logic             InstrValid,
  input  logic             MemReady,
  input  logic             Zero,
  output logic             InstrReq,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             Reg2Loc,
  output logic             ALUSrc,
  output logic             MemToReg,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic             UncondBranch,
  output logic [1:0]       ALUOP,
  output logic [2:0]       State,
  output logic             Illegal,
  output logic             MemError,
  output logic [CNT_W-1:0] Retired
);

  // states: FETCH 0 | DECODE 1 | EXECUTE 2 | MEMORY 3 | WRITEBACK 4 | TRAP 7 (held until reset)
  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXECUTE = 3'd2,
    S_MEMORY = 3'd3, S_WRITEBACK = 3'd4, S_TRAP = 3'd7
  } state_t;

  typedef enum logic [2:0] {C_LDUR, C_STUR, C_CBZ, C_B, C_RTYPE, C_ILLEGAL} class_t;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           state_q, state_d;
  class_t           cls_q, cls_dec;
  logic [7:0]       wait_q, wait_d;
  logic             illegal_q, mem_error_q;
  logic [CNT_W-1:0] retired_q;
  logic             retire, set_illegal, set_mem_error;
  logic             instr_req, ir_write, pc_write;

  always_comb begin
    cls_dec = C_ILLEGAL;
    casez (OPCode)
      11'b11111000010: cls_dec = C_LDUR;
      11'b11111000000: cls_dec = C_STUR;
      11'b10110100???: cls_dec = C_CBZ;
      11'b000101?????: cls_dec = C_B;
      11'b10001011000, 11'b11001011000, 11'b10001010000,
      11'b10101010000, 11'b11010011011, 11'b11010011010: cls_dec = C_RTYPE;
      default:         cls_dec = C_ILLEGAL;
    endcase
  end

  always_ff @(posedge CLK or negedge nReset) begin
    if (!nReset) begin
      state_q     <= S_FETCH;
      cls_q       <= C_ILLEGAL;
      wait_q      <= '0;
      illegal_q   <= 1'b0;
      mem_error_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (state_q == S_DECODE) cls_q <= cls_dec;
      if (set_illegal) illegal_q <= 1'b1;
      if (set_mem_error) mem_error_q <= 1'b1;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    retire        = 1'b0;
    set_illegal   = 1'b0;
    set_mem_error = 1'b0;
    instr_req     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    Reg2Loc       = 1'b0;
    ALUSrc        = 1'b0;
    MemToReg      = 1'b0;
    RegWrite      = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    Branch        = 1'b0;
    UncondBranch  = 1'b0;
    ALUOP         = 2'b00;
    case (state_q)
      S_FETCH: begin
        instr_req = 1'b1;
        if (InstrValid) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // class register is not loaded yet, so this state decodes OPCode directly
        Reg2Loc = (cls_dec == C_STUR) || (cls_dec == C_CBZ);
        if (cls_dec == C_ILLEGAL) begin
          set_illegal = 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
          retire  = 1'b1;
`endif
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        Reg2Loc = (cls_q == C_STUR) || (cls_q == C_CBZ);
        ALUSrc  = (cls_q == C_LDUR) || (cls_q == C_STUR);
        case (cls_q)
          C_LDUR, C_STUR: state_d = S_MEMORY;
          C_CBZ: begin
            ALUOP    = 2'b01;
            Branch   = 1'b1;
            pc_write = Zero;
            state_d  = S_FETCH;
            retire   = 1'b1;
          end
          C_B: begin
            UncondBranch = 1'b1;
            pc_write     = 1'b1;
            state_d      = S_FETCH;
            retire       = 1'b1;
          end
          C_RTYPE: begin
            ALUOP   = 2'b10;
            state_d = S_WRITEBACK;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMORY: begin
        ALUSrc   = 1'b1;
        MemRead  = (cls_q == C_LDUR);
        MemWrite = (cls_q == C_STUR);
        if (MemReady) begin
          wait_d = '0;
          if (cls_q == C_LDUR) begin
            state_d = S_WRITEBACK;
          end else begin
            state_d = S_FETCH;
            retire  = 1'b1;
          end
        end else if (wait_q == WAIT_LAST) begin
          wait_d        = '0;
          set_mem_error = 1'b1;
          state_d       = S_FETCH;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WRITEBACK: begin
        RegWrite = 1'b1;
        MemToReg = (cls_q == C_LDUR);
        if (cls_q == C_RTYPE) ALUOP = 2'b10;
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // FETCH is the reset state, so its outputs are masked while reset is held
  assign InstrReq = instr_req & nReset;
  assign IRWrite  = ir_write & nReset;
  assign PCWrite  = pc_write & nReset;
  assign State    = state_q;
  assign Illegal  = illegal_q;
  assign MemError = mem_error_q;
  assign Retired  = retired_q;

endmodule
